// File: rtl/calc_pkg.sv
// Shared calculator definitions: ALU opcodes and sequencer state encoding.
// The ALU and the multi-precision sequencer both take their opcodes from here.
package calc_pkg;

  localparam logic [2:0] OPT_NULL = 3'd0;
  localparam logic [2:0] OPT_ADD  = 3'd1;
  localparam logic [2:0] OPT_SUB  = 3'd2;
  localparam logic [2:0] OPT_AND  = 3'd3;
  localparam logic [2:0] OPT_ORR  = 3'd4;
  localparam logic [2:0] OPT_CMP  = 3'd5;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_DONE
  } seq_state_e;

endpackage

// File: rtl/alu_mp_sequencer.sv
// Multi-precision initiator for the 8-bit ALU, LSB byte first, carry chained.
// ALU_MP_SIGNED_OVF_EN enables signed overflow tracking on the top byte.
module alu_mp_sequencer
  import calc_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [8*NBYTES-1:0]   opa,
  input  logic [8*NBYTES-1:0]   opb,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry,
  output logic                  zero,
  output logic                  ovf,
  output logic [2:0]            alu_opt,
  output logic [7:0]            alu_numa,
  output logic [7:0]            alu_numb,
  output logic                  alu_ci,
  input  logic [7:0]            alu_s,
  input  logic                  alu_zero,
  input  logic                  alu_co
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  seq_state_e      state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [2:0]      op_q, op_d;
  logic [W-1:0]    opa_q, opa_d;
  logic [W-1:0]    opb_q, opb_d;
  logic [W-1:0]    result_q, result_d;
  logic            cin_q, cin_d;
  logic            zacc_q, zacc_d;
  logic            carry_q, carry_d;
  logic            zero_q, zero_d;
`ifdef ALU_MP_SIGNED_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEQ_IDLE;
      idx_q    <= '0;
      op_q     <= OPT_NULL;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      cin_q    <= 1'b0;
      zacc_q   <= 1'b1;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
`ifdef ALU_MP_SIGNED_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      cin_q    <= cin_d;
      zacc_q   <= zacc_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
`ifdef ALU_MP_SIGNED_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    cin_d    = cin_q;
    zacc_d   = zacc_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
`ifdef ALU_MP_SIGNED_OVF_EN
    ovf_d    = ovf_q;
`endif
    busy     = 1'b0;
    done     = 1'b0;
    alu_opt  = OPT_NULL;
    alu_numa = '0;
    alu_numb = '0;
    alu_ci   = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          op_d    = op;
          opa_d   = opa;
          opb_d   = opb;
          idx_d   = '0;
          cin_d   = 1'b0;
          zacc_d  = 1'b1;
          state_d = SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        busy     = 1'b1;
        alu_opt  = op_q;
        alu_numa = opa_q[8*idx_q +: 8];
        alu_numb = opb_q[8*idx_q +: 8];
        alu_ci   = cin_q;
        // CMP only reports flags; the previous result stays visible
        if (op_q != OPT_CMP) begin
          result_d[8*idx_q +: 8] = alu_s;
        end
        cin_d  = alu_co;
        zacc_d = zacc_q & alu_zero;
        if (idx_q == LAST) begin
          state_d = SEQ_DONE;
          carry_d = alu_co;
          zero_d  = zacc_q & alu_zero;
`ifdef ALU_MP_SIGNED_OVF_EN
          unique case (1'b1)
            op_q == OPT_ADD:
              ovf_d = (alu_numa[7] == alu_numb[7]) &
                      (alu_s[7] != alu_numa[7]);
            op_q == OPT_SUB,
            op_q == OPT_CMP:
              ovf_d = (alu_numa[7] != alu_numb[7]) &
                      (alu_s[7] != alu_numa[7]);
            default:
              ovf_d = 1'b0;
          endcase
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SEQ_DONE: begin
        done    = 1'b1;
        state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
`ifdef ALU_MP_SIGNED_OVF_EN
  assign ovf    = ovf_q;
`else
  assign ovf    = 1'b0;
`endif

endmodule
